// File: rtl/adc_fifo_writer.sv
// Write-side controller for the ADC acquisition FIFO: snapshots a sample set on a
// rising DRDY edge and pushes the words, highest index first, stalling on WRFULL.
module adc_fifo_writer #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  DRDY,
    input  logic                  WRFULL,
    input  logic                  WREMPTY,
    input  logic [DATA_WIDTH-1:0] DATA [NUM_WORDS-1:0],
    output logic                  WRREQ,
    output logic [DATA_WIDTH-1:0] WRDATA
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]            state;
    logic [IW-1:0]         index;
    logic [DATA_WIDTH-1:0] snap [NUM_WORDS-1:0];
    logic                  drdy_q;
    logic                  start;
    logic                  unused_wrempty;

    assign unused_wrempty = WREMPTY;
    assign start          = DRDY & ~drdy_q;
    assign WRREQ          = (state == WRITE) & ~WRFULL;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state  <= IDLE;
            index  <= '0;
            drdy_q <= 1'b0;
            WRDATA <= '0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            drdy_q <= DRDY;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                            snap[i] <= DATA[i];
                        end
                        // WRDATA is loaded straight from DATA so the first word is valid
                        // in the first WRITE cycle without waiting on the snapshot.
                        WRDATA <= DATA[NUM_WORDS-1];
                        index  <= IW'(NUM_WORDS - 1);
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (WRREQ) begin
                        if (index == '0) begin
                            state <= IDLE;
                        end else begin
                            index  <= index - 1'b1;
                            WRDATA <= snap[index - 1'b1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_fifo_writer.sv
// Directed bench for adc_fifo_writer: a vector table for reset/burst/stall/full-at-start,
// plus hand-written sequences for retrigger and reset mid-burst.
module tb_adc_fifo_writer;

    localparam int DW = 64;
    localparam int NW = 4;

    localparam logic [DW-1:0] VA = 64'hAAAA_0000_0000_000A;
    localparam logic [DW-1:0] VB = 64'hBBBB_0000_0000_000B;
    localparam logic [DW-1:0] VC = 64'hCCCC_0000_0000_000C;
    localparam logic [DW-1:0] VD = 64'hDDDD_0000_0000_000D;

    logic          clk = 1'b0;
    logic          rst;
    logic          drdy;
    logic          full;
    logic          empty;
    logic [DW-1:0] data [NW-1:0];
    logic          wrreq;
    logic [DW-1:0] wrdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          r;
        logic          d;
        logic          f;
        logic          ereq;
        logic [DW-1:0] edata;
    } vec_t;

    vec_t vecs[$];

    adc_fifo_writer #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .CLK    (clk),
        .nRST   (rst),
        .DRDY   (drdy),
        .WRFULL (full),
        .WREMPTY(empty),
        .DATA   (data),
        .WRREQ  (wrreq),
        .WRDATA (wrdata)
    );

    always #5 clk = ~clk;

    task automatic set_data(input logic [DW-1:0] a, b, c, d);
        data[3] = a;
        data[2] = b;
        data[1] = c;
        data[0] = d;
    endtask

    task automatic add(input logic r, d, f, q, input logic [DW-1:0] w);
        vec_t v;
        v.r = r; v.d = d; v.f = f; v.ereq = q; v.edata = w;
        vecs.push_back(v);
    endtask

    // Apply inputs for one cycle, check outputs within that cycle, then cross the edge.
    task automatic cyc(input logic r, d, f, q, input logic [DW-1:0] w, input string nm);
        rst = r; drdy = d; full = f;
        #1;
        total++;
        if (wrreq !== q) begin
            bad++;
            $display("FAIL %s wrreq: got %b want %b", nm, wrreq, q);
        end
        total++;
        if (wrdata !== w) begin
            bad++;
            $display("FAIL %s wrdata: got %h want %h", nm, wrdata, w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; drdy = 1'b0; full = 1'b0; empty = 1'b1;
        set_data(VA, VB, VC, VD);

        // reset, single burst, level held high
        add(1,0,0, 0,'0); add(0,0,0, 0,'0); add(0,0,0, 0,'0);
        add(0,1,0, 0,'0);
        add(0,1,0, 1,VA); add(0,1,0, 1,VB); add(0,1,0, 1,VC); add(0,1,0, 1,VD);
        add(0,1,0, 0,VD); add(0,1,0, 0,VD);
        // stall two cycles while B is presented
        add(0,0,0, 0,VD); add(0,1,0, 0,VD);
        add(0,1,0, 1,VA); add(0,1,1, 0,VB); add(0,1,1, 0,VB);
        add(0,1,0, 1,VB); add(0,1,0, 1,VC); add(0,1,0, 1,VD); add(0,1,0, 0,VD);
        // full before the edge, held for five cycles
        add(0,0,1, 0,VD); add(0,1,1, 0,VD);
        add(0,1,1, 0,VA); add(0,1,1, 0,VA); add(0,1,1, 0,VA); add(0,1,1, 0,VA);
        add(0,1,0, 1,VA); add(0,1,0, 1,VB); add(0,1,0, 1,VC); add(0,1,0, 1,VD);
        add(0,1,0, 0,VD);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].d, vecs[i].f, vecs[i].ereq, vecs[i].edata,
                $sformatf("vec%0d", i));
        end

        // retrigger with new data; edges mid-burst and on the last word are dropped
        cyc(0,0,0, 0,VD, "rt_low");
        set_data(64'd1, 64'd2, 64'd3, 64'd4);
        cyc(0,1,0, 0,VD, "rt_edge");
        set_data(64'h99, 64'h99, 64'h99, 64'h99);
        cyc(0,0,0, 1,64'd1, "rt_w1");
        cyc(0,1,0, 1,64'd2, "rt_w2");
        cyc(0,0,0, 1,64'd3, "rt_w3");
        cyc(0,1,0, 1,64'd4, "rt_w4");
        cyc(0,1,0, 0,64'd4, "rt_idle1");
        cyc(0,1,0, 0,64'd4, "rt_idle2");

        // reset after two words, then a fresh burst from DATA[3]
        set_data(VA, VB, VC, VD);
        cyc(0,0,0, 0,64'd4, "rm_low");
        cyc(0,1,0, 0,64'd4, "rm_edge");
        cyc(0,1,0, 1,VA, "rm_w1");
        cyc(1,0,0, 1,VB, "rm_w2_rst");
        cyc(0,0,0, 0,'0, "rm_after");
        cyc(0,0,0, 0,'0, "rm_idle");
        cyc(0,1,0, 0,'0, "rm_edge2");
        cyc(0,1,0, 1,VA, "rm_n1");
        cyc(0,1,0, 1,VB, "rm_n2");
        cyc(0,1,0, 1,VC, "rm_n3");
        cyc(0,1,0, 1,VD, "rm_n4");
        cyc(0,1,0, 0,VD, "rm_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
